// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, ID redirect flushes, data-memory wait freeze.
// Zero-cycle latency (outputs combinational); optional perf counters under `HAZARD_CTRL_PERF_EN.
module hazard_ctrl #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rsaddr_i,
    input  logic [4:0]       id_rtaddr_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rtaddr_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_we_o,
    output logic             idex_bubble_o,
    output logic             exmem_we_o,
    output logic             memwb_bubble_o,
    output logic             stall_o,
`ifdef HAZARD_CTRL_PERF_EN
    output logic [CNT_W-1:0] lu_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] wait_cnt_o,
`endif
    output logic             mem_err_o
);

    localparam int WC_W = $clog2(WAIT_MAX + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(WAIT_MAX);
    localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t          state_q, state_nxt;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_nxt;
    logic            lu_q, lu_q_nxt;
    logic            err_q, err_nxt;

    logic lu, mw, redirect, lu_take;

    // Register 0 is hardwired, so a load targeting it can never create a hazard.
    assign lu = ex_memread_i && (ex_rtaddr_i != 5'd0) &&
                ((ex_rtaddr_i == id_rsaddr_i) ||
                 (id_uses_rt_i && (ex_rtaddr_i == id_rtaddr_i)));
    assign mw       = mem_req_i && !mem_ack_i;
    assign redirect = branch_taken_i || jump_i;
    assign lu_take  = (state_q == RUN) && !mw && lu && !lu_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            lu_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            wait_cnt_q <= wait_cnt_nxt;
            lu_q       <= lu_q_nxt;
            err_q      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        wait_cnt_nxt = wait_cnt_q;
        lu_q_nxt     = lu_q;
        err_nxt      = err_q;
        case (state_q)
            RUN: begin
                // lu_q only survives the cycle that took the bubble: one bubble per load-use pair.
                lu_q_nxt = lu_take;
                if (mw) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WC_ONE;
                    if (WC_ONE >= WC_MAX) err_nxt = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ack_i) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    if (wait_cnt_q < WC_MAX) wait_cnt_nxt = wait_cnt_q + WC_ONE;
                    if (wait_cnt_nxt >= WC_MAX) err_nxt = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_we_o        = 1'b1;
        ifid_we_o      = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_we_o      = 1'b1;
        idex_bubble_o  = 1'b0;
        exmem_we_o     = 1'b1;
        memwb_bubble_o = 1'b0;
        stall_o        = 1'b0;
        mem_err_o      = err_q;
        if (rst_i) begin
            pc_we_o        = 1'b0;
            ifid_we_o      = 1'b0;
            idex_we_o      = 1'b0;
            exmem_we_o     = 1'b0;
            ifid_flush_o   = 1'b1;
            idex_bubble_o  = 1'b1;
            memwb_bubble_o = 1'b1;
            stall_o        = 1'b1;
            mem_err_o      = 1'b0;
        end else if (state_q == MEM_WAIT || mw) begin
            pc_we_o        = 1'b0;
            ifid_we_o      = 1'b0;
            idex_we_o      = 1'b0;
            exmem_we_o     = 1'b0;
            memwb_bubble_o = 1'b1;
            stall_o        = 1'b1;
        end else if (lu_take) begin
            // ID is held, so a branch here is simply re-evaluated next cycle.
            pc_we_o       = 1'b0;
            ifid_we_o     = 1'b0;
            idex_bubble_o = 1'b1;
            stall_o       = 1'b1;
        end else if (redirect) begin
            ifid_flush_o = 1'b1;
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lu_cnt_o    <= '0;
            flush_cnt_o <= '0;
            wait_cnt_o  <= '0;
        end else begin
            if (lu_take)             lu_cnt_o    <= lu_cnt_o + 1'b1;
            if (ifid_flush_o)        flush_cnt_o <= flush_cnt_o + 1'b1;
            if (state_q == MEM_WAIT) wait_cnt_o  <= wait_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: stateful vector table through a scoreboard queue, plus hand-written corner sequences.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       uses_rt, memrd, br, jmp, req, ack;
    logic       pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble, stall, mem_err;
`ifdef HAZARD_CTRL_PERF_EN
    logic [7:0] lu_cnt, flush_cnt, wait_cnt;
`endif

    hazard_ctrl #(.WAIT_MAX(4), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_rsaddr_i(id_rs), .id_rtaddr_i(id_rt), .id_uses_rt_i(uses_rt),
        .ex_memread_i(memrd), .ex_rtaddr_i(ex_rt),
        .branch_taken_i(br), .jump_i(jmp),
        .mem_req_i(req), .mem_ack_i(ack),
        .pc_we_o(pc_we), .ifid_we_o(ifid_we), .ifid_flush_o(ifid_flush),
        .idex_we_o(idex_we), .idex_bubble_o(idex_bubble), .exmem_we_o(exmem_we),
        .memwb_bubble_o(memwb_bubble), .stall_o(stall),
`ifdef HAZARD_CTRL_PERF_EN
        .lu_cnt_o(lu_cnt), .flush_cnt_o(flush_cnt), .wait_cnt_o(wait_cnt),
`endif
        .mem_err_o(mem_err)
    );

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       memrd;
        logic [4:0] exrt;
        logic       br;
        logic       jmp;
        logic       req;
        logic       ack;
    } vin_t;

    typedef struct packed {
        vin_t       in;
        logic [8:0] exp;
    } vec_t;

    // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble, stall, mem_err}
    localparam logic [8:0] E_RST = 9'b0_0_1_0_1_0_1_1_0;
    localparam logic [8:0] E_N   = 9'b1_1_0_1_0_1_0_0_0;
    localparam logic [8:0] E_NE  = 9'b1_1_0_1_0_1_0_0_1;
    localparam logic [8:0] E_LU  = 9'b0_0_0_1_1_1_0_1_0;
    localparam logic [8:0] E_BR  = 9'b1_1_1_1_0_1_0_0_0;
    localparam logic [8:0] E_FZ  = 9'b0_0_0_0_0_0_1_1_0;
    localparam logic [8:0] E_FZE = 9'b0_0_0_0_0_0_1_1_1;

    logic [8:0] sb_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic vin_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                input logic u, input logic m, input logic [4:0] ert,
                                input logic b, input logic j, input logic rq, input logic ak);
        vin_t v;
        v.rst = r; v.rs = rs; v.rt = rt; v.uses = u; v.memrd = m; v.exrt = ert;
        v.br = b; v.jmp = j; v.req = rq; v.ack = ak;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, req_v);
        end
    endtask

    // Drive one cycle's inputs, queue its expectation, compare mid-cycle, then advance past the edge.
    task automatic step(input vin_t v, input logic [8:0] exp, input string name);
        logic [8:0] e;
        rst = v.rst; id_rs = v.rs; id_rt = v.rt; uses_rt = v.uses; memrd = v.memrd;
        ex_rt = v.exrt; br = v.br; jmp = v.jmp; req = v.req; ack = v.ack;
        sb_q.push_back(exp);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            check(name, {23'd0, pc_we, ifid_we, ifid_flush, idex_we, idex_bubble,
                         exmem_we, memwb_bubble, stall, mem_err}, {23'd0, e});
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[33];
    vin_t IDLE, RST, LU_RS, REQ, ACK;

    initial begin
        IDLE  = mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0, 0);
        RST   = mk(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0, 0);
        LU_RS = mk(0, 5'd5, 5'd9, 0, 1, 5'd5, 0, 0, 0, 0);
        REQ   = mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 1, 0);
        ACK   = mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 1, 1);

        tbl[0]  = '{RST,   E_RST};
        tbl[1]  = '{IDLE,  E_N};
        tbl[2]  = '{LU_RS, E_LU};
        tbl[3]  = '{LU_RS, E_N};
        tbl[4]  = '{IDLE,  E_N};
        tbl[5]  = '{mk(0, 5'd0, 5'd3, 0, 1, 5'd0, 0, 0, 0, 0), E_N};
        tbl[6]  = '{mk(0, 5'd3, 5'd7, 0, 1, 5'd7, 0, 0, 0, 0), E_N};
        tbl[7]  = '{mk(0, 5'd3, 5'd7, 1, 1, 5'd7, 0, 0, 0, 0), E_LU};
        tbl[8]  = '{IDLE,  E_N};
        tbl[9]  = '{mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, 0, 0), E_BR};
        tbl[10] = '{mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0, 0), E_BR};
        tbl[11] = '{mk(0, 5'd5, 5'd9, 0, 1, 5'd5, 1, 0, 0, 0), E_LU};
        tbl[12] = '{mk(0, 5'd5, 5'd9, 0, 1, 5'd5, 1, 0, 0, 0), E_BR};
        tbl[13] = '{IDLE,  E_N};
        tbl[14] = '{ACK,   E_N};
        tbl[15] = '{REQ,   E_FZ};
        tbl[16] = '{mk(0, 5'd5, 5'd9, 0, 1, 5'd5, 1, 0, 1, 0), E_FZ};
        tbl[17] = '{mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 1, 0), E_FZ};
        tbl[18] = '{ACK,   E_FZ};
        tbl[19] = '{IDLE,  E_N};
        tbl[20] = '{REQ,   E_FZ};
        tbl[21] = '{REQ,   E_FZ};
        tbl[22] = '{REQ,   E_FZ};
        tbl[23] = '{REQ,   E_FZ};
        tbl[24] = '{REQ,   E_FZE};
        tbl[25] = '{REQ,   E_FZE};
        tbl[26] = '{ACK,   E_FZE};
        tbl[27] = '{IDLE,  E_NE};
        tbl[28] = '{RST,   E_RST};
        tbl[29] = '{IDLE,  E_N};
        tbl[30] = '{REQ,   E_FZ};
        tbl[31] = '{mk(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 1, 0), E_RST};
        tbl[32] = '{IDLE,  E_N};

        rst = 1'b1; id_rs = '0; id_rt = '0; uses_rt = 0; memrd = 0; ex_rt = '0;
        br = 0; jmp = 0; req = 0; ack = 0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 33; i++)
            step(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));

        // A load-use held indefinitely alternates bubble / pass.
        for (int i = 0; i < 4; i++)
            step(LU_RS, (i % 2 == 0) ? E_LU : E_N, $sformatf("lu_hold%0d", i));

        // Memory wait entered while a load-use bubble is pending: freeze wins.
        step(mk(0, 5'd5, 5'd9, 0, 1, 5'd5, 0, 0, 1, 0), E_FZ, "mw_over_lu");
        step(mk(0, 5'd5, 5'd9, 0, 1, 5'd5, 0, 0, 1, 1), E_FZ, "mw_ack_lu");
        step(LU_RS, E_LU, "lu_after_wait");
        step(IDLE, E_N, "idle_after_wait");

`ifdef HAZARD_CTRL_PERF_EN
        step(RST, E_RST, "perf_rst");
        step(LU_RS, E_LU, "perf_lu1");
        step(IDLE, E_N, "perf_i1");
        step(LU_RS, E_LU, "perf_lu2");
        step(IDLE, E_N, "perf_i2");
        step(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, 0, 0), E_BR, "perf_br1");
        step(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, 0, 0), E_BR, "perf_br2");
        step(mk(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0, 0), E_BR, "perf_j");
        step(REQ, E_FZ, "perf_w0");
        step(REQ, E_FZ, "perf_w1");
        step(REQ, E_FZ, "perf_w2");
        step(REQ, E_FZ, "perf_w3");
        step(REQ, E_FZE, "perf_w4");
        step(ACK, E_FZE, "perf_ack");
        step(IDLE, E_NE, "perf_done");
        check("lu_cnt", {24'd0, lu_cnt}, 32'd2);
        check("flush_cnt", {24'd0, flush_cnt}, 32'd3);
        check("wait_cnt", {24'd0, wait_cnt}, 32'd5);
`endif

        if (sb_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
